pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//   Program-counter stage of the single-cycle MIPS datapath. Holds the PC register,
//   forms PC+4 with the 32-bit adder (add32), and selects the next PC from four
//   sources: sequential, branch, jump and jump-register. Its outputs feed the
//   instruction memory address and the PC+4 link value.
//   A two-state run/halt FSM halts the core on a misaligned jump-register target.
//   A retired-instruction counter supports bench checking.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset; must be word aligned
// PORTS
//   clk            in   1   rising-edge clock (the design's only clock)
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   hold PC and counter this cycle
//   branch_taken   in   1   branch condition resolved true (beq/bne)
//   branch_imm     in   16  instr[15:0], signed word offset
//   jump           in   1   j/jal
//   jump_index     in   26  instr[25:0]
//   jump_reg       in   1   jr
//   reg_target     in   32  rs value for jr
//   pc             out  32  current PC, to instruction memory
//   pc_plus4       out  32  pc+4 (combinational, from add32), to jal link and branch adder
//   retired_count  out  32  instructions retired since reset
//   halted         out  1   core halted after a misaligned jr
// BEHAVIOUR
//   - Interface: one clock, clk; reset is synchronous and active-high (reset).
//     All state updates occur on the rising edge of clk.
//   - Reset values: pc=RESET_PC, retired_count=0, halted=0, FSM=RUN.
//     Reset has priority over every other input, including in HALT.
//   - Arithmetic:
//     - pc_plus4 = pc + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0.
//     - branch_tgt = pc_plus4 + ({{14{imm[15]}},imm,2'b00}), modulo 2^32.
//     - jump_tgt = {pc_plus4[31:28], jump_index, 2'b00}.
//   - Next-PC priority, one-hot not required:
//     jump_reg > jump > branch_taken > sequential (pc_plus4).
//   - FSM RUN:
//     - If stall=1: pc and retired_count hold; all select inputs are ignored.
//     - Else if jump_reg=1 and reg_target[1:0]!=0: pc holds, halted<=1,
//       FSM->HALT. The jr is not counted as retired.
//     - Else: pc <= selected next PC and retired_count <= retired_count+1
//       (wraps 0xFFFF_FFFF->0).
//   - FSM HALT: pc, retired_count and halted hold; only reset leaves HALT.
//   - Latency: a select input applied in cycle N appears on pc after edge N+1.
//     pc_plus4 follows pc combinationally.
//   - stall together with jump_reg and a misaligned target: stall wins, no halt.
// TESTING
//   1. Reset, then 4 free-running cycles -> pc 0,4,8,12,16; retired_count=4.
//   2. pc=0x100, branch_taken=1, imm=16'hFFFE -> next pc=0xFC;
//      imm=16'h0003 -> next pc=0x110.
//   3. pc=0x1000_0008, jump=1, index=26'h0000040 -> pc=0x1000_0100.
//      Same cycle with jump_reg=1, reg_target=0x200 -> pc=0x200 (jr wins).
//   4. stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20, count unchanged.
//      Release -> pc=0x24.
//   5. jump_reg=1, reg_target=0x202 -> halted=1, pc holds, count frozen.
//      Further jumps are ignored. reset=1 -> pc=RESET_PC, halted=0.
//   6. Force pc=0xFFFF_FFFC by jr -> next sequential pc=0x0.
//      Reset asserted mid-branch -> pc=RESET_PC on that edge.

Source files
------------

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit : program-counter stage of the single-cycle MIPS datapath.
//
// Holds the PC register and forms PC+4 with a 32-bit adder (add32). The next
// PC comes from one of four sources, in this priority order: jump-register,
// jump, branch, sequential. A two-state run/halt FSM stops the core when a jr
// targets a misaligned address. A retired-instruction counter is also kept.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   hold PC and counter this cycle
//   branch_taken   in   1   branch condition resolved true
//   branch_imm     in   16  signed word offset (instr[15:0])
//   jump           in   1   j / jal
//   jump_index     in   26  instr[25:0]
//   jump_reg       in   1   jr
//   reg_target     in   32  rs value for jr
//   pc             out  32  current PC (registered)
//   pc_plus4       out  32  pc + 4 (combinational)
//   retired_count  out  32  instructions retired since reset (registered)
//   halted         out  1   core halted after a misaligned jr (registered)
// ---------------------------------------------------------------------------

module add32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);
   assign sum = a + b;
endmodule

module pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] reg_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] retired_count,
   output logic        halted
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] count_r;
   logic [31:0] count_next_s;
   logic        halted_r;
   logic        halted_next_s;

   logic [31:0] pc_plus4_s;
   logic [31:0] branch_off_s;
   logic [31:0] branch_tgt_s;
   logic [31:0] jump_tgt_s;
   logic [31:0] sel_pc_s;
   logic        misaligned_jr_s;

   add32 u_add_pc4 (
      .a   (pc_r),
      .b   (32'h0000_0004),
      .sum (pc_plus4_s)
   );

   // Sign-extended immediate scaled to bytes.
   assign branch_off_s = {{14{branch_imm[15]}}, branch_imm, 2'b00};

   add32 u_add_br (
      .a   (pc_plus4_s),
      .b   (branch_off_s),
      .sum (branch_tgt_s)
   );

   assign jump_tgt_s      = {pc_plus4_s[31:28], jump_index, 2'b00};
   assign misaligned_jr_s = jump_reg & (reg_target[1:0] != 2'b00);

   // Next-PC source selection: jr > j > branch > sequential.
   always_comb begin
      sel_pc_s = pc_plus4_s;
      if (jump_reg) begin
         sel_pc_s = reg_target;
      end else if (jump) begin
         sel_pc_s = jump_tgt_s;
      end else if (branch_taken) begin
         sel_pc_s = branch_tgt_s;
      end else begin
         sel_pc_s = pc_plus4_s;
      end
   end

   // Run/halt FSM next state and next values of PC, counter and halt flag.
   always_comb begin
      state_next_s  = state_r;
      pc_next_s     = pc_r;
      count_next_s  = count_r;
      halted_next_s = halted_r;
      case (state_r)
         ST_RUN: begin
            if (stall) begin
               // Stall outranks everything, including a misaligned jr.
               pc_next_s    = pc_r;
               count_next_s = count_r;
            end else if (misaligned_jr_s) begin
               // Faulting jr: PC holds and the jr does not retire.
               state_next_s  = ST_HALT;
               halted_next_s = 1'b1;
            end else begin
               pc_next_s    = sel_pc_s;
               count_next_s = count_r + 32'd1;
            end
         end
         ST_HALT: begin
            state_next_s  = ST_HALT;
            halted_next_s = 1'b1;
         end
         default: begin
            // An illegal state is treated as a fault and parks the core.
            state_next_s  = ST_HALT;
            halted_next_s = 1'b1;
         end
      endcase
   end

   // State register; reset outranks every other input, including HALT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r  <= ST_RUN;
         pc_r     <= RESET_PC;
         count_r  <= 32'd0;
         halted_r <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         pc_r     <= pc_next_s;
         count_r  <= count_next_s;
         halted_r <= halted_next_s;
      end
   end

   assign pc            = pc_r;
   assign pc_plus4      = pc_plus4_s;
   assign retired_count = count_r;
   assign halted        = halted_r;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_index;
   logic        jump_reg;
   logic [31:0] reg_target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] retired_count;
   logic        halted;

   int n_checks;
   int n_fail;

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic        m_halt;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        br;
      logic [15:0] imm;
      logic        j;
      logic [25:0] idx;
      logic        jr;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_cnt;
      logic        exp_halt;
   } vec_t;

   vec_t vq[$];

   pc_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_imm    (branch_imm),
      .jump          (jump),
      .jump_index    (jump_index),
      .jump_reg      (jump_reg),
      .reg_target    (reg_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .retired_count (retired_count),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic stl, input logic br, input logic [15:0] imm,
                        input logic j, input logic [25:0] idx, input logic jr, input logic [31:0] tgt);
      @(negedge clk);
      reset        = rst;
      stall        = stl;
      branch_taken = br;
      branch_imm   = imm;
      jump         = j;
      jump_index   = idx;
      jump_reg     = jr;
      reg_target   = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input logic rst, input logic stl, input logic br, input logic [15:0] imm,
                          input logic j, input logic [25:0] idx, input logic jr, input logic [31:0] tgt,
                          input logic [31:0] epc, input logic [31:0] ecnt, input logic eh);
      vec_t v;
      v.rst = rst; v.stl = stl; v.br = br; v.imm = imm; v.j = j; v.idx = idx;
      v.jr = jr; v.tgt = tgt; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_halt = eh;
      vq.push_back(v);
   endtask

   // Behavioural model: one clock edge applied to the architectural state.
   task automatic model_step();
      logic [31:0] seq;
      logic signed [31:0] off;
      if (reset) begin
         m_pc = 32'h0; m_cnt = 32'h0; m_halt = 1'b0;
      end else if (m_halt || stall) begin
         // nothing changes
      end else if (jump_reg && (reg_target % 32'd4 != 32'd0)) begin
         m_halt = 1'b1;
      end else begin
         seq = m_pc + 32'd4;
         off = $signed(branch_imm) * 32'sd4;
         if (jump_reg)          m_pc = reg_target;
         else if (jump)         m_pc = (seq & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
         else if (branch_taken) m_pc = seq + off;
         else                   m_pc = seq;
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   task automatic check_model(input string tag);
      check32({tag, " pc"}, pc, m_pc);
      check32({tag, " pc_plus4"}, pc_plus4, m_pc + 32'd4);
      check32({tag, " count"}, retired_count, m_cnt);
      check32({tag, " halted"}, {31'd0, halted}, {31'd0, m_halt});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // Directed sequence starting from reset (pc=0, count=0).
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0004, 32'd1, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0008, 32'd2, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_000C, 32'd3, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0010, 32'd4, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h100,       32'h0000_0100, 32'd5, 0);
      add_vec(0,0,1,16'hFFFE,0,26'h0,0,32'h0,      32'h0000_00FC, 32'd6, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h100,       32'h0000_0100, 32'd7, 0);
      add_vec(0,0,1,16'h0003,0,26'h0,0,32'h0,      32'h0000_0110, 32'd8, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h1000_0008, 32'h1000_0008, 32'd9, 0);
      add_vec(0,0,0,16'h0,1,26'h40,0,32'h0,        32'h1000_0100, 32'd10, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h1000_0008, 32'h1000_0008, 32'd11, 0);
      add_vec(0,0,1,16'h5,1,26'h40,1,32'h200,      32'h0000_0200, 32'd12, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h20,        32'h0000_0020, 32'd13, 0);
      add_vec(0,1,1,16'h7,1,26'h40,1,32'h202,      32'h0000_0020, 32'd13, 0);
      add_vec(0,1,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0020, 32'd13, 0);
      add_vec(0,1,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0020, 32'd13, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0024, 32'd14, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd15, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0000, 32'd16, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0004, 32'd17, 0);
      add_vec(1,0,1,16'h0003,0,26'h0,0,32'h0,      32'h0000_0000, 32'd0, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h40,        32'h0000_0040, 32'd1, 0);
      add_vec(0,0,0,16'h0,0,26'h0,1,32'h202,       32'h0000_0040, 32'd1, 1);
      add_vec(0,0,0,16'h0,1,26'h40,0,32'h0,        32'h0000_0040, 32'd1, 1);
      add_vec(0,0,1,16'h3,0,26'h0,1,32'h100,       32'h0000_0040, 32'd1, 1);
      add_vec(1,0,0,16'h0,1,26'h40,0,32'h0,        32'h0000_0000, 32'd0, 0);
      add_vec(0,0,1,16'hFFFE,0,26'h0,0,32'h0,      32'hFFFF_FFFC, 32'd1, 0);
      add_vec(0,0,0,16'h0,0,26'h0,0,32'h0,         32'h0000_0000, 32'd2, 0);

      // Reset state.
      drive(1,0,0,16'h0,0,26'h0,0,32'h0);
      check32("reset pc", pc, 32'h0);
      check32("reset pc_plus4", pc_plus4, 32'h4);
      check32("reset count", retired_count, 32'h0);
      check32("reset halted", {31'd0, halted}, 32'h0);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].stl, vq[i].br, vq[i].imm, vq[i].j, vq[i].idx, vq[i].jr, vq[i].tgt);
         check32($sformatf("vec%0d pc", i), pc, vq[i].exp_pc);
         check32($sformatf("vec%0d pc_plus4", i), pc_plus4, vq[i].exp_pc + 32'd4);
         check32($sformatf("vec%0d count", i), retired_count, vq[i].exp_cnt);
         check32($sformatf("vec%0d halted", i), {31'd0, halted}, {31'd0, vq[i].exp_halt});
      end

      // Hand-written: reset while halted and stalled must still win.
      drive(0,0,0,16'h0,0,26'h0,1,32'h1);
      check32("halt seq halted", {31'd0, halted}, 32'h1);
      drive(1,1,0,16'h0,0,26'h0,1,32'h3);
      check32("reset-in-halt pc", pc, 32'h0);
      check32("reset-in-halt halted", {31'd0, halted}, 32'h0);

      // Randomized phase against the model.
      m_pc = 32'h0; m_cnt = 32'h0; m_halt = 1'b0;
      for (int n = 0; n < 600; n++) begin
         logic        r_rst, r_stl, r_br, r_j, r_jr;
         logic [31:0] r_tgt, rnd;
         logic [15:0] r_imm;
         logic [25:0] r_idx;
         r_rst = ($urandom_range(0, 39) == 0);
         r_stl = ($urandom_range(0, 4) == 0);
         r_br  = ($urandom_range(0, 2) == 0);
         r_j   = ($urandom_range(0, 3) == 0);
         r_jr  = ($urandom_range(0, 5) == 0);
         rnd   = $urandom;
         r_imm = rnd[15:0];
         rnd   = $urandom;
         r_idx = rnd[25:0];
         rnd   = $urandom;
         if ($urandom_range(0, 7) == 0) r_tgt = rnd;
         else                           r_tgt = {rnd[31:2], 2'b00};
         drive(r_rst, r_stl, r_br, r_imm, r_j, r_idx, r_jr, r_tgt);
         model_step();
         check_model($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
